// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch/decode boundary of the RISC-V core.
//   XLEN          : width of instruction, PC and PC+4 fields
//   NOP_INSTR     : addi x0,x0,0, shown to decode when nothing is queued
//   fetch_entry_t : one queued fetch result {instr, pc, pc_plus4}
//   next_pc       : sequential PC helper (PC + 4, wraps mod 2^XLEN)
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_queue_storage.sv
// ---------------------------------------------------------------------------
// fetchq_storage
// DEPTH x fetch_entry_t register array with one synchronous write port and
// one asynchronous read port. Contents are not reset; the owning queue
// masks unwritten slots using its occupancy count.
// Ports:
//   clk      in  : core clock
//   wr_en    in  : write wr_data into slot wr_addr on the rising edge
//   wr_addr  in  : write slot index
//   wr_data  in  : entry to store
//   rd_addr  in  : read slot index
//   rd_data  out : entry currently held at rd_addr (combinational)
// ---------------------------------------------------------------------------
module fetchq_storage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          mem_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Decoupling FIFO between instruction fetch and decode. Buffers
// {instruction, PC, PC+4} entries so an imem burst survives decode stalls,
// presents the head entry to decode, and is emptied on a redirect.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   defined   : an entry offered into an empty queue is forwarded to the
//               decode outputs in the same cycle (and not stored if decode
//               consumes it immediately).
//   undefined : outputs depend only on registered state; 1-cycle latency.
//
// Ports:
//   clk       in  : core clock, all state on rising edge
//   rst       in  : asynchronous active-low reset
//   InValid   in  : fetch offers an entry
//   InReady   out : queue can accept an entry (not full)
//   InstrF    in  : fetched instruction word
//   PCF       in  : PC of InstrF
//   OutValid  out : head entry valid for decode
//   OutReady  in  : decode consumes the head this cycle
//   InstrD    out : head instruction, NOP_INSTR when empty
//   PCD       out : head PC, 0 when empty
//   PCPlus4D  out : head PC+4, 0 when empty
//   Flush     in  : synchronous discard of all entries (wins over push/pop)
//   Count     out : current occupancy
// ---------------------------------------------------------------------------
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [XLEN-1:0]          InstrF,
  input  logic [XLEN-1:0]          PCF,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [XLEN-1:0]          InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  input  logic                     Flush,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  fetch_entry_t in_entry;
  fetch_entry_t head_entry;

  logic empty;
  logic full;
  logic push;
  logic bypass;
  logic wr_en;
  logic rd_en;

  fetchq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head_entry)
  );

  // Handshake and next-state control
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    in_entry = '{instr: InstrF, pc: PCF, pc_plus4: next_pc(PCF)};

    // A push offered in a flush cycle is dropped.
    push = InValid && !full && !Flush;

`ifdef FETCHQ_BYPASS_EN
    bypass = empty && InValid && !Flush;
`else
    bypass = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle is never stored.
    wr_en = push && !(bypass && OutReady);
    // Pops of stored entries only; OutReady while empty is ignored.
    rd_en = !empty && OutReady && !Flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Decode-side outputs
  always_comb begin
    InReady = !full;
    Count   = count_q;
    if (bypass) begin
      OutValid = 1'b1;
      InstrD   = in_entry.instr;
      PCD      = in_entry.pc;
      PCPlus4D = in_entry.pc_plus4;
    end else if (!empty) begin
      OutValid = 1'b1;
      InstrD   = head_entry.instr;
      PCD      = head_entry.pc;
      PCPlus4D = head_entry.pc_plus4;
    end else begin
      OutValid = 1'b0;
      InstrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Decoupling queue between instruction fetch and decode in the RISC-V core.
- Buffers fetched {instruction, PC, PC+4} entries so an imem burst survives decode stalls.
- Presents the head entry as the decode-stage instruction word. Decode slices it into register fields and into the immediate handed to the sign-extend unit.
- Flushed on taken branch/jump redirect.

Parameters:
DEPTH, 4, number of entries; power of two, 2..16
XLEN, 32, width of instruction, PC and PC+4 fields
NOP_INSTR, 32'h00000013, word presented on InstrD when empty or after reset (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
InValid  input  1  fetch offers an entry this cycle
InReady  output  1  queue accepts an entry this cycle
InstrF  input  XLEN  fetched instruction word
PCF  input  XLEN  PC of InstrF
OutValid  output  1  head entry valid for decode
OutReady  input  1  decode consumes head this cycle (not stalled)
InstrD  output  XLEN  head instruction; NOP_INSTR when empty
PCD  output  XLEN  head PC; 0 when empty
PCPlus4D  output  XLEN  head PC+4; 0 when empty
Flush  input  1  synchronous discard of all entries (redirect)
Count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, async): rd/wr pointers 0, Count 0, OutValid 0, InReady 1, InstrD NOP_INSTR, PCD 0, PCPlus4D 0. Takes effect mid-transfer; entries in flight are lost.
- Push = InValid && InReady. Pop = OutValid && OutReady.
- InReady = (Count != DEPTH); purely from registered state, no combinational path from OutReady.
- OutValid = (Count != 0). Head fields driven from storage at rd pointer. Empty -> NOP_INSTR/0/0.
- PCPlus4 computed at push time: PCF + 4 mod 2^XLEN. PCF 32'hFFFFFFFC stores PCPlus4 0.
- Latency: a push into an empty queue appears on OutValid/InstrD the next cycle.
- Push and pop in the same cycle: Count unchanged; both pointers advance.
- Full: InReady 0; a simultaneous pop does not enable a push that cycle.
- Pointers wrap modulo DEPTH. Count carries the extra bit that distinguishes full from empty.
- Flush has priority over push and pop in the same cycle:
  - next cycle Count 0, pointers 0, OutValid 0;
  - any push offered in the flush cycle is dropped;
  - storage contents need not be cleared.
- OutReady while empty: ignored, no state change.
- Ordering: strict FIFO. No entry is duplicated or reordered.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined: when Count == 0 and InValid is high (and Flush is low), the input is forwarded combinationally:
  - OutValid 1, InstrD = InstrF, PCD = PCF, PCPlus4D = PCF + 4, all in the same cycle;
  - if OutReady is also high, the entry is consumed and not written (Count stays 0);
  - otherwise it is written as normal.
- Undefined: no bypass. Minimum push-to-output latency is 1 cycle, and outputs depend only on registered state.

Decomposition:
- Package riscv_pkg: XLEN, NOP_INSTR constant, typedef fetch_entry_t {instr, pc, pc_plus4}.
- One sub-module, fetchq_storage: DEPTH x fetch_entry_t register array, one write port and one async read port.
- Pointer/count control stays in instr_fetch_queue.

Test Plan:
1. Reset: rst low mid-stream with Count 3 -> immediately OutValid 0, Count 0, InstrD 32'h00000013, InReady 1.
2. Fill/drain: OutReady 0, push PCs 0x0,0x4,0x8,0xC -> Count 4, InReady 0; then OutReady 1 -> PCD 0x0,0x4,0x8,0xC on consecutive cycles, PCPlus4D 0x4..0x10.
3. Full + simultaneous pop: Count 4, InValid 1, OutReady 1 -> that input is not accepted, Count 3 next cycle; the entry is accepted the following cycle.
4. Steady stream: InValid and OutReady held 1 for 20 cycles -> Count steady at 1, throughput 1/cycle, order preserved.
5. Flush: Count 2, Flush 1 with InValid 1 (PC 0x40) -> next cycle Count 0, OutValid 0; 0x40 never appears on PCD.
6. Wrap/edge: PCF 32'hFFFFFFFC -> PCPlus4D 0. Pointer wrap after 9 pushes/pops with DEPTH 4 -> data intact. With FETCHQ_BYPASS_EN and an empty queue, InstrF appears on InstrD the same cycle.
